// File: rtl/spi_slave.sv
// SPI mode-0 slave with all pins oversampled in clk_i; 1-entry TX/RX holding registers.
// Optional feature: define SPI_SLAVE_OVERRUN_EN to drop words on overrun and flag rx_overrun_o.
module spi_slave #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] TX_IDLE = DATA_W'(8'hFF)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sclk_i,
  input  logic              cs_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_load_i,
  output logic              tx_empty_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              rx_overrun_o
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
  state_t state_q, state_d;

  logic [1:0]        sclk_s, cs_s, mosi_s;
  logic              sclk_q, cs_q;
  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [DATA_W-1:0] tx_hold, tx_sh, rx_sh;
  logic              tx_full;
  logic [CNT_W-1:0]  bit_cnt;
  logic              last_bit, frame_done, commit_q, hs;
  logic              tx_reload, do_rise, do_fall, abort;

  // [1] is the synchronised value; *_q is the edge-detect register behind it
  assign sclk_rise = sclk_s[1] & ~sclk_q;
  assign sclk_fall = ~sclk_s[1] & sclk_q;
  assign cs_rise   = cs_s[1] & ~cs_q;
  assign cs_fall   = ~cs_s[1] & cs_q;
  assign last_bit  = (bit_cnt == CNT_W'(DATA_W-1));
  assign hs        = rx_valid_o & rx_ready_i;
  assign tx_empty_o = ~tx_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy_o    = 1'b0;
    miso_o    = 1'b0;
    tx_reload = 1'b0;
    do_rise   = 1'b0;
    do_fall   = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_SHIFT;
          tx_reload = 1'b1;
        end
      end
      ST_SHIFT: begin
        busy_o = 1'b1;
        miso_o = tx_sh[DATA_W-1];
        if (cs_rise) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else begin
          do_rise   = sclk_rise;
          do_fall   = sclk_fall;
          tx_reload = sclk_fall & frame_done;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_s     <= 2'b00;
      cs_s       <= 2'b11;
      mosi_s     <= 2'b00;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      tx_hold    <= '0;
      tx_full    <= 1'b0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      commit_q   <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], sclk_i};
      cs_s   <= {cs_s[0], cs_i};
      mosi_s <= {mosi_s[0], mosi_i};
      sclk_q <= sclk_s[1];
      cs_q   <= cs_s[1];

      if (tx_reload)    tx_sh <= tx_full ? tx_hold : TX_IDLE;
      else if (do_fall) tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};

      // a load coinciding with a shifter reload keeps the new word pending
      if (tx_load_i) begin
        tx_hold <= tx_data_i;
        tx_full <= 1'b1;
      end else if (tx_reload) begin
        tx_full <= 1'b0;
      end

      if (abort) begin
        bit_cnt    <= '0;
        frame_done <= 1'b0;
      end else begin
        if (do_rise) begin
          rx_sh   <= {rx_sh[DATA_W-2:0], mosi_s[1]};
          bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
        end
        if (do_rise && last_bit) frame_done <= 1'b1;
        else if (do_fall)        frame_done <= 1'b0;
      end
      commit_q <= do_rise & last_bit;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else if (commit_q) begin
      if (rx_valid_o && !hs) begin
        rx_overrun_o <= 1'b1;
      end else begin
        rx_data_o  <= rx_sh;
        rx_valid_o <= 1'b1;
      end
    end else if (hs) begin
      rx_valid_o <= 1'b0;
    end
  end
`else
  assign rx_overrun_o = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
    end else if (commit_q) begin
      rx_data_o  <= rx_sh;
      rx_valid_o <= 1'b1;
    end else if (hs) begin
      rx_valid_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master with hand-computed expected bytes.
module tb_spi_slave;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_empty;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       busy, rx_overrun;

  int checks = 0;
  int fails  = 0;

  logic [7:0] rx_log[4];
  int         log_cnt = 0;
  bit         log_en  = 1'b0;

  spi_slave #(.DATA_W(8), .TX_IDLE(8'hFF)) dut (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_i(cs), .mosi_i(mosi), .miso_o(miso),
    .tx_data_i(tx_data), .tx_load_i(tx_load), .tx_empty_o(tx_empty),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .busy_o(busy), .rx_overrun_o(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (log_en && rx_valid && rx_ready && log_cnt < 4) begin
      rx_log[log_cnt] = rx_data;
      log_cnt++;
    end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] v);
    tx_data = v; tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
  endtask

  task automatic cs_low;
    cs = 1'b0; wait_clk(8);
  endtask

  task automatic cs_high;
    cs = 1'b1; wait_clk(8);
  endtask

  task automatic ack;
    rx_ready = 1'b1; wait_clk(1);
    rx_ready = 1'b0; wait_clk(1);
  endtask

  // Master shifts nbits of mo MSB first; sclk half period is 8 clk cycles
  task automatic spi_xfer(input int nbits, input logic [7:0] mo, input bit do_load,
                          input logic [7:0] ld_val, output logic [7:0] mi);
    mi = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      mosi = mo[7-k];
      if (do_load && k == 4) begin
        wait_clk(2); load_tx(ld_val); wait_clk(5);
      end else begin
        wait_clk(8);
      end
      mi[7-k] = miso;
      sclk = 1'b1; wait_clk(8);
      sclk = 1'b0;
    end
    wait_clk(8);
  endtask

  task automatic test_reset;
    rst = 1'b1; wait_clk(3);
    checks++; if (miso !== 1'b0)       begin fails++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (tx_empty !== 1'b1)   begin fails++; $display("FAIL reset_tx_empty got=%b exp=1", tx_empty); end
    checks++; if (rx_data !== 8'h00)   begin fails++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0)   begin fails++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rx_overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%b exp=0", rx_overrun); end
    rst = 1'b0; wait_clk(4);
  endtask

  task automatic test_basic;
    logic [7:0] mi;
    load_tx(8'hA5);
    checks++; if (tx_empty !== 1'b0) begin fails++; $display("FAIL basic_loaded got=%b exp=0", tx_empty); end
    cs_low;
    checks++; if (tx_empty !== 1'b1) begin fails++; $display("FAIL basic_empty_after_cs got=%b exp=1", tx_empty); end
    checks++; if (busy !== 1'b1)     begin fails++; $display("FAIL basic_busy got=%b exp=1", busy); end
    spi_xfer(8, 8'h3C, 1'b0, 8'h00, mi);
    checks++; if (mi !== 8'hA5)       begin fails++; $display("FAIL basic_miso got=%h exp=a5", mi); end
    checks++; if (rx_valid !== 1'b1)  begin fails++; $display("FAIL basic_rx_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== 8'h3C)  begin fails++; $display("FAIL basic_rx_data got=%h exp=3c", rx_data); end
    ack;
    checks++; if (rx_valid !== 1'b0)  begin fails++; $display("FAIL basic_valid_clear got=%b exp=0", rx_valid); end
    cs_high;
    checks++; if (busy !== 1'b0)      begin fails++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    checks++; if (miso !== 1'b0)      begin fails++; $display("FAIL basic_idle_miso got=%b exp=0", miso); end
  endtask

  task automatic test_idle_word;
    logic [7:0] mi;
    cs_low;
    spi_xfer(8, 8'h00, 1'b0, 8'h00, mi);
    checks++; if (mi !== 8'hFF)      begin fails++; $display("FAIL idle_miso got=%h exp=ff", mi); end
    checks++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL idle_rx_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL idle_rx_data got=%h exp=00", rx_data); end
    ack;
    cs_high;
  endtask

  task automatic test_back_to_back;
    logic [7:0] mi1, mi2;
    log_cnt = 0; rx_ready = 1'b1; log_en = 1'b1;
    load_tx(8'h81);
    cs_low;
    spi_xfer(8, 8'h11, 1'b1, 8'h42, mi1);
    spi_xfer(8, 8'h22, 1'b0, 8'h00, mi2);
    checks++; if (mi1 !== 8'h81)     begin fails++; $display("FAIL b2b_miso0 got=%h exp=81", mi1); end
    checks++; if (mi2 !== 8'h42)     begin fails++; $display("FAIL b2b_miso1 got=%h exp=42", mi2); end
    checks++; if (tx_empty !== 1'b1) begin fails++; $display("FAIL b2b_tx_empty got=%b exp=1", tx_empty); end
    checks++; if (log_cnt !== 2)     begin fails++; $display("FAIL b2b_count got=%0d exp=2", log_cnt); end
    checks++; if (rx_log[0] !== 8'h11) begin fails++; $display("FAIL b2b_rx0 got=%h exp=11", rx_log[0]); end
    checks++; if (rx_log[1] !== 8'h22) begin fails++; $display("FAIL b2b_rx1 got=%h exp=22", rx_log[1]); end
    checks++; if (busy !== 1'b1)     begin fails++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    cs_high;
    log_en = 1'b0; rx_ready = 1'b0; wait_clk(1);
  endtask

  task automatic test_abort;
    logic [7:0] mi;
    cs_low;
    spi_xfer(5, 8'hF8, 1'b0, 8'h00, mi);
    cs_high;
    checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL abort_no_valid got=%b exp=0", rx_valid); end
    checks++; if (busy !== 1'b0)     begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
    cs_low;
    spi_xfer(8, 8'h5A, 1'b0, 8'h00, mi);
    checks++; if (mi !== 8'hFF)      begin fails++; $display("FAIL abort_next_miso got=%h exp=ff", mi); end
    checks++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL abort_next_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== 8'h5A) begin fails++; $display("FAIL abort_next_data got=%h exp=5a", rx_data); end
    ack;
    cs_high;
  endtask

  task automatic test_overrun;
    logic [7:0] mi;
    logic [7:0] exp_data;
    logic       exp_ovr;
`ifdef SPI_SLAVE_OVERRUN_EN
    exp_data = 8'h01; exp_ovr = 1'b1;
`else
    exp_data = 8'h02; exp_ovr = 1'b0;
`endif
    rx_ready = 1'b0;
    cs_low;
    spi_xfer(8, 8'h01, 1'b0, 8'h00, mi);
    spi_xfer(8, 8'h02, 1'b0, 8'h00, mi);
    cs_high;
    checks++; if (rx_valid !== 1'b1)     begin fails++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== exp_data)  begin fails++; $display("FAIL ovr_data got=%h exp=%h", rx_data, exp_data); end
    checks++; if (rx_overrun !== exp_ovr) begin fails++; $display("FAIL ovr_flag got=%b exp=%b", rx_overrun, exp_ovr); end
    ack;
  endtask

  task automatic test_reset_midframe;
    logic [7:0] mi;
    load_tx(8'h96);
    cs_low;
    spi_xfer(3, 8'hE0, 1'b0, 8'h00, mi);
    rst = 1'b1; cs = 1'b1; wait_clk(1);
    checks++; if (miso !== 1'b0)       begin fails++; $display("FAIL rstmid_miso got=%b exp=0", miso); end
    checks++; if (tx_empty !== 1'b1)   begin fails++; $display("FAIL rstmid_tx_empty got=%b exp=1", tx_empty); end
    checks++; if (rx_data !== 8'h00)   begin fails++; $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0)   begin fails++; $display("FAIL rstmid_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (busy !== 1'b0)       begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (rx_overrun !== 1'b0) begin fails++; $display("FAIL rstmid_overrun got=%b exp=0", rx_overrun); end
    wait_clk(1); rst = 1'b0; wait_clk(8);
    checks++; if (busy !== 1'b0)       begin fails++; $display("FAIL rstmid_stay_idle got=%b exp=0", busy); end
    cs_low;
    spi_xfer(8, 8'hC3, 1'b0, 8'h00, mi);
    checks++; if (mi !== 8'hFF)        begin fails++; $display("FAIL rstmid_miso_after got=%h exp=ff", mi); end
    checks++; if (rx_valid !== 1'b1)   begin fails++; $display("FAIL rstmid_valid_after got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== 8'hC3)   begin fails++; $display("FAIL rstmid_data_after got=%h exp=c3", rx_data); end
    ack;
    cs_high;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_idle_word;
    test_back_to_back;
    test_abort;
    test_overrun;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
